// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared core/memory constants and the memory request record
package gpu_pkg;

    localparam int NUM_CORES     = 16;
    localparam int SLOW_LAT      = 10;
    localparam int FAST_LAT      = 3;
    localparam int FAST_BANK_BIT = 15;
    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic int read_latency(input logic [ADDR_W-1:0] addr, input int slow, input int fast);
        return addr[FAST_BANK_BIT] ? fast : slow;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with rotating start pointer
module rr_arbiter #(
    parameter  int N  = 16,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any,
    output logic [PW-1:0] next_ptr
);

    always_comb begin
        int k;
        logic [PW-1:0] idx;
        k         = 0;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        next_ptr  = ptr;
        // Scan ptr, ptr+1, ... modulo N; the first hit wins.
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            idx = PW'(k);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
                next_ptr   = (k == N - 1) ? '0 : PW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port among cores with fixed per-bank read latency
module mem_port_arbiter #(
    parameter int NUM_CORES = gpu_pkg::NUM_CORES,
    parameter int SLOW_LAT  = gpu_pkg::SLOW_LAT,
    parameter int FAST_LAT  = gpu_pkg::FAST_LAT
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_CORES-1:0]                req_valid,
    input  logic [NUM_CORES-1:0]                req_write,
    input  logic [gpu_pkg::ADDR_W*NUM_CORES-1:0] req_addr,
    input  logic [gpu_pkg::DATA_W*NUM_CORES-1:0] req_wdata,
    output logic [NUM_CORES-1:0]                req_ready,
    output logic [NUM_CORES-1:0]                rsp_valid,
    output logic [gpu_pkg::DATA_W*NUM_CORES-1:0] rsp_data,
    output logic                                mem_en,
    output logic                                mem_we,
    output logic [gpu_pkg::ADDR_W-1:0]          mem_addr,
    output logic [gpu_pkg::DATA_W-1:0]          mem_wdata,
    input  logic [gpu_pkg::DATA_W-1:0]          mem_rdata
);
    import gpu_pkg::*;

    localparam int PW      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int MAX_LAT = (SLOW_LAT > FAST_LAT) ? SLOW_LAT : FAST_LAT;
    localparam int TW      = $clog2(MAX_LAT + 1);

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        next_ptr;
    logic [PW-1:0]        win_idx;
    logic                 any_grant;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] grant;
    logic [NUM_CORES-1:0] busy;
    logic [TW-1:0]        timer   [NUM_CORES];
    logic [DATA_W-1:0]    rdata_q [NUM_CORES];
    logic                 cap_valid;
    logic [PW-1:0]        cap_idx;
    mem_req_t             win_req;

    assign eligible = req_valid & ~busy;

    rr_arbiter #(.N(NUM_CORES)) u_rr (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (win_idx),
        .any       (any_grant),
        .next_ptr  (next_ptr)
    );

    assign req_ready = grant;

    always_comb begin
        win_req = '0;
        if (any_grant) begin
            win_req.write = req_write[win_idx];
            win_req.addr  = req_addr[win_idx*ADDR_W +: ADDR_W];
            win_req.wdata = req_wdata[win_idx*DATA_W +: DATA_W];
        end
    end

    assign mem_en    = any_grant;
    assign mem_we    = win_req.write;
    assign mem_addr  = win_req.addr;
    assign mem_wdata = win_req.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            busy      <= '0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                timer[i]   <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            if (any_grant) begin
                rr_ptr <= next_ptr;
            end
            // Memory returns read data one cycle after the grant; park it per core.
            cap_valid <= any_grant & ~win_req.write;
            cap_idx   <= win_idx;
            if (cap_valid) begin
                rdata_q[cap_idx] <= mem_rdata;
            end
            for (int i = 0; i < NUM_CORES; i++) begin
                if (timer[i] != '0) begin
                    timer[i] <= timer[i] - 1'b1;
                end
                if (timer[i] == TW'(1)) begin
                    busy[i] <= 1'b0;
                end
            end
            // Only idle cores are eligible, so this never collides with a running timer.
            if (any_grant && !win_req.write) begin
                busy[win_idx]  <= 1'b1;
                timer[win_idx] <= TW'(read_latency(win_req.addr, SLOW_LAT, FAST_LAT));
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (timer[i] == TW'(1)) begin
                rsp_valid[i]                   = 1'b1;
                rsp_data[i*DATA_W +: DATA_W] = rdata_q[i];
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int N = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [16*N-1:0] req_addr, req_wdata, rsp_data;
    logic            mem_en, mem_we;
    logic [15:0]     mem_addr, mem_wdata;
    logic [15:0]     mem_rdata = '0;
    logic [15:0]     mem [0:65535];
    int              total = 0;
    int              bad = 0;

    always #5 clk = ~clk;

    // Both banks in one array: bit 15 of the address picks the bank.
    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int c, input logic wr, input logic [15:0] a, input logic [15:0] d);
        req_valid[c]         = 1'b1;
        req_write[c]         = wr;
        req_addr[c*16 +: 16]  = a;
        req_wdata[c*16 +: 16] = d;
    endtask

    task automatic write_word(input int c, input logic [15:0] a, input logic [15:0] d);
        set_req(c, 1'b1, a, d);
        step();
        clear_reqs();
    endtask

    // Entered one cycle after the grant; k counts cycles since the grant.
    task automatic wait_rsp(input int c, input int limit, output int lat, output logic [15:0] data);
        lat  = -1;
        data = '0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (rsp_valid[c]) begin
                lat  = k;
                data = rsp_data[c*16 +: 16];
                step();
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        clear_reqs();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%h rsp_valid=%h rsp_data_nonzero=%0d required all zero", req_ready, rsp_valid, rsp_data != '0);
        end
        total++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0) begin
            bad++;
            $display("FAIL reset_mem: en=%b we=%b addr=%h required 0 0 0000", mem_en, mem_we, mem_addr);
        end
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        total++;
        if (mem_en !== 1'b0 || req_ready !== '0) begin
            bad++;
            $display("FAIL idle_after_reset: en=%b ready=%h required 0 0000", mem_en, req_ready);
        end
        step();
    endtask

    task automatic test_slow_read();
        int lat;
        logic [15:0] d;
        write_word(15, 16'h0005, 16'h1234);
        set_req(0, 1'b0, 16'h0005, 16'h0);
        @(negedge clk);
        total++;
        if (req_ready !== 16'h0001) begin
            bad++;
            $display("FAIL slow_grant: ready=%h required 0001", req_ready);
        end
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0005) begin
            bad++;
            $display("FAIL slow_mem_drive: en=%b we=%b addr=%h required 1 0 0005", mem_en, mem_we, mem_addr);
        end
        step();
        clear_reqs();
        wait_rsp(0, 20, lat, d);
        total++;
        if (lat != 10) begin
            bad++;
            $display("FAIL slow_latency: got %0d required 10", lat);
        end
        total++;
        if (d !== 16'h1234) begin
            bad++;
            $display("FAIL slow_data: got %h required 1234", d);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== '0 || rsp_data !== '0) begin
            bad++;
            $display("FAIL slow_pulse_width: rsp_valid=%h required 0000 after pulse", rsp_valid);
        end
        step();
    endtask

    task automatic test_fast_read();
        int lat;
        logic [15:0] d;
        write_word(15, 16'h8003, 16'hABCD);
        set_req(1, 1'b0, 16'h8003, 16'h0);
        @(negedge clk);
        total++;
        if (req_ready !== 16'h0002) begin
            bad++;
            $display("FAIL fast_grant: ready=%h required 0002", req_ready);
        end
        step();
        clear_reqs();
        wait_rsp(1, 20, lat, d);
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL fast_latency: got %0d required 3", lat);
        end
        total++;
        if (d !== 16'hABCD) begin
            bad++;
            $display("FAIL fast_data: got %h required abcd", d);
        end
    endtask

    task automatic test_all_cores();
        logic [N-1:0] exp_g, exp_r;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'(i), 16'h0);
        // Held requests: cycle c grants core c%16; each read answers 10 cycles later.
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            exp_g = '0;
            exp_g[c % N] = 1'b1;
            exp_r = '0;
            if (c >= 10) exp_r[(c - 10) % N] = 1'b1;
            total++;
            if (req_ready !== exp_g || mem_addr !== 16'(c % N)) begin
                bad++;
                $display("FAIL rotation_grant c=%0d: ready=%h addr=%h required %h %h", c, req_ready, mem_addr, exp_g, 16'(c % N));
            end
            total++;
            if (rsp_valid !== exp_r) begin
                bad++;
                $display("FAIL rotation_rsp c=%0d: rsp_valid=%h required %h", c, rsp_valid, exp_r);
            end
            step();
        end
        clear_reqs();
        repeat (12) step();
    endtask

    task automatic test_write_then_read();
        int we_cnt, rsp_cnt, lat;
        logic [15:0] d;
        we_cnt = 0;
        rsp_cnt = 0;
        lat = -1;
        d = '0;
        set_req(3, 1'b1, 16'h0007, 16'hBEEF);
        @(negedge clk);
        total++;
        if (req_ready !== 16'h0008 || mem_we !== 1'b1 || mem_addr !== 16'h0007 || mem_wdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL raw_write: ready=%h we=%b addr=%h wdata=%h required 0008 1 0007 beef", req_ready, mem_we, mem_addr, mem_wdata);
        end
        if (mem_we) we_cnt++;
        step();
        set_req(3, 1'b0, 16'h0007, 16'h0);
        @(negedge clk);
        total++;
        if (req_ready !== 16'h0008 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL raw_read_grant: ready=%h we=%b required 0008 0", req_ready, mem_we);
        end
        if (rsp_valid[3]) rsp_cnt++;
        step();
        clear_reqs();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (rsp_valid[3]) begin
                rsp_cnt++;
                lat = k;
                d = rsp_data[3*16 +: 16];
            end
            step();
        end
        total++;
        if (we_cnt != 1 || rsp_cnt != 1) begin
            bad++;
            $display("FAIL raw_counts: we_pulses=%0d responses=%0d required 1 1", we_cnt, rsp_cnt);
        end
        total++;
        if (lat != 10 || d !== 16'hBEEF) begin
            bad++;
            $display("FAIL raw_read: latency=%0d data=%h required 10 beef", lat, d);
        end
    endtask

    task automatic test_hold_busy();
        int early, lat;
        logic regrant;
        early = 0;
        lat = -1;
        regrant = 1'b0;
        set_req(2, 1'b0, 16'h0005, 16'h0);
        @(negedge clk);
        total++;
        if (req_ready !== 16'h0004) begin
            bad++;
            $display("FAIL hold_first_grant: ready=%h required 0004", req_ready);
        end
        step();
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k <= 10 && req_ready[2]) early++;
            if (rsp_valid[2] && lat < 0) lat = k;
            if (k == 11) regrant = req_ready[2];
            step();
        end
        clear_reqs();
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL hold_blocked: grants while busy=%0d required 0", early);
        end
        total++;
        if (lat != 10 || regrant !== 1'b1) begin
            bad++;
            $display("FAIL hold_regrant: rsp latency=%0d regrant=%b required 10 1", lat, regrant);
        end
        repeat (12) step();
    endtask

    task automatic test_reset_mid_read();
        int seen, lat;
        logic [15:0] d;
        seen = 0;
        set_req(5, 1'b0, 16'h0005, 16'h0);
        @(negedge clk);
        total++;
        if (req_ready !== 16'h0020) begin
            bad++;
            $display("FAIL mid_reset_grant: ready=%h required 0020", req_ready);
        end
        step();
        clear_reqs();
        repeat (3) step();
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== '0 || req_ready !== '0 || mem_en !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: rsp_valid=%h ready=%h en=%b required 0000 0000 0", rsp_valid, req_ready, mem_en);
        end
        step();
        step();
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid !== '0) seen++;
            step();
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_reset_dropped: response cycles=%0d required 0", seen);
        end
        // Pointer back at 0 picks core 5 over core 7; a stale pointer of 6 would pick 7.
        set_req(5, 1'b0, 16'h0005, 16'h0);
        set_req(7, 1'b0, 16'h0006, 16'h0);
        @(negedge clk);
        total++;
        if (req_ready !== 16'h0020) begin
            bad++;
            $display("FAIL mid_reset_ptr: ready=%h required 0020", req_ready);
        end
        step();
        clear_reqs();
        wait_rsp(5, 20, lat, d);
        total++;
        if (lat != 10 || d !== 16'h1234) begin
            bad++;
            $display("FAIL mid_reset_read: latency=%0d data=%h required 10 1234", lat, d);
        end
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_slow_read();
        test_fast_read();
        test_all_cores();
        test_write_then_read();
        test_hold_busy();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
